// File: rtl/mem_sdp_init.sv
// Simple-dual-port RAM: port A byte-lane writes, port B reads with 1 or 2 cycle latency.
// A clear engine zeroes the whole array after reset or when clr is pulsed.
module mem_sdp_init #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 512,
  parameter int BYTE_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0,
  parameter int CLEAR_ON_RST = 1,
  localparam int NB          = WIDTH / BYTE_W,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             busy,
  input  logic             enA,
  input  logic [NB-1:0]    weA,
  input  logic [AW-1:0]    addrA,
  input  logic [WIDTH-1:0] dinA,
  input  logic             enB,
  input  logic [AW-1:0]    addrB,
  output logic [WIDTH-1:0] doutB,
  output logic             validB
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic            in_a, in_b, wr_ok, rd_ok;
  logic [WIDTH-1:0] rd_word;
  logic            v1;
  logic [WIDTH-1:0] d1;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        cnt_n = cnt + AW'(1);
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy  = (state == CLEAR);
  // Addresses past DEPTH exist only for non-power-of-two depths.
  assign in_a  = ({1'b0, addrA} < DEPTH_X);
  assign in_b  = ({1'b0, addrB} < DEPTH_X);
  assign wr_ok = enA && !busy && !rst && in_a;
  assign rd_ok = enB && !busy && !rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[cnt] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < NB; i++) begin
          if (weA[i]) mem[addrA][i*BYTE_W +: BYTE_W] <= dinA[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Write-first merges the lanes being written this cycle into the read word.
  always_comb begin
    rd_word = '0;
    if (in_b) begin
      rd_word = mem[addrB];
      if ((WRITE_FIRST != 0) && wr_ok && (addrA == addrB)) begin
        for (int i = 0; i < NB; i++) begin
          if (weA[i]) rd_word[i*BYTE_W +: BYTE_W] = dinA[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) d1 <= rd_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic             v2;
      logic [WIDTH-1:0] d2;

      always_ff @(posedge clk) begin
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign doutB  = d2;
      assign validB = v2;
    end else begin : g_lat1
      assign doutB  = d1;
      assign validB = v1;
    end
  endgenerate

endmodule

// File: tb/tb_mem_sdp_init.sv
// Directed bench for mem_sdp_init: one 512-deep latency-1 read-first instance and
// one 300-deep latency-2 write-first instance share the same stimulus.
module tb_mem_sdp_init;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        enA;
  logic [3:0]  weA;
  logic [8:0]  addrA;
  logic [31:0] dinA;
  logic        enB;
  logic [8:0]  addrB;

  logic        busy_a, valid_a, busy_b, valid_b;
  logic [31:0] dout_a, dout_b;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  we;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[16];

  mem_sdp_init #(
    .WIDTH(32), .DEPTH(512), .BYTE_W(8),
    .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RST(1)
  ) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA),
    .enB(enB), .addrB(addrB), .doutB(dout_a), .validB(valid_a)
  );

  mem_sdp_init #(
    .WIDTH(32), .DEPTH(300), .BYTE_W(8),
    .READ_LATENCY(2), .WRITE_FIRST(1), .CLEAR_ON_RST(1)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA),
    .enB(enB), .addrB(addrB), .doutB(dout_b), .validB(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle read (any port A inputs already set are applied in the same cycle).
  task automatic do_read(input string name, input logic [8:0] addr,
                         input logic [31:0] exp_a, input logic [31:0] exp_b);
    enB   = 1'b1;
    addrB = addr;
    step();
    enB = 1'b0;
    enA = 1'b0;
    checkOutput({name, " valid_a@1"}, 32'(valid_a), 32'd1);
    checkOutput({name, " dout_a"}, dout_a, exp_a);
    checkOutput({name, " valid_b@1"}, 32'(valid_b), 32'd0);
    step();
    checkOutput({name, " valid_a@2"}, 32'(valid_a), 32'd0);
    checkOutput({name, " valid_b@2"}, 32'(valid_b), 32'd1);
    checkOutput({name, " dout_b"}, dout_b, exp_b);
  endtask

  task automatic do_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] we);
    enA   = 1'b1;
    addrA = addr;
    dinA  = data;
    weA   = we;
    step();
    enA = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.rd) do_read($sformatf("vec%0d", idx), v.addr, v.exp_a, v.exp_b);
    else      do_write(v.addr, v.data, v.we);
  endtask

  // Counts busy cycles from the current sample point until both engines are idle.
  task automatic count_clear(output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (!busy_a && !busy_b) break;
      step();
    end
  endtask

  initial begin
    int ca, cb, stray;

    vecs[0]  = '{1'b1, 9'd0,   32'h0,        4'h0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 9'd255, 32'h0,        4'h0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 9'd511, 32'h0,        4'h0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 9'd5,   32'hAABBCCDD, 4'hF, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 9'd5,   32'h11223344, 4'h5, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 9'd5,   32'h0,        4'h0, 32'hAA22CC44, 32'hAA22CC44};
    vecs[6]  = '{1'b0, 9'd1,   32'h10,       4'hF, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 9'd2,   32'h11,       4'hF, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 9'd3,   32'h12,       4'hF, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 9'd4,   32'h13,       4'hF, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 9'd44,  32'h0000BEEF, 4'hF, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 9'd300, 32'h0000DEAD, 4'hF, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 9'd44,  32'h0,        4'h0, 32'h0000BEEF, 32'h0000BEEF};
    vecs[13] = '{1'b1, 9'd300, 32'h0,        4'h0, 32'h0000DEAD, 32'h0};
    vecs[14] = '{1'b0, 9'd299, 32'hCAFE0001, 4'hF, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 9'd299, 32'h0,        4'h0, 32'hCAFE0001, 32'hCAFE0001};

    rst = 1'b1; clr = 1'b0; enA = 1'b0; weA = '0; addrA = '0; dinA = '0;
    enB = 1'b0; addrB = '0;

    // Reset state and power-up clear length.
    step();
    step();
    checkOutput("rst valid_a", 32'(valid_a), 32'd0);
    checkOutput("rst dout_a", dout_a, 32'h0);
    checkOutput("rst valid_b", 32'(valid_b), 32'd0);
    checkOutput("rst dout_b", dout_b, 32'h0);
    checkOutput("rst busy_a", 32'(busy_a), 32'd1);
    checkOutput("rst busy_b", 32'(busy_b), 32'd1);
    rst = 1'b0;
    count_clear(ca, cb);
    checkOutput("init clear len a", ca, 32'd512);
    checkOutput("init clear len b", cb, 32'd300);

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

    // Four back-to-back reads of addresses 1..4.
    for (int k = 0; k < 6; k++) begin
      enB   = (k < 4);
      addrB = 9'(k + 1);
      step();
      checkOutput($sformatf("tput%0d valid_a", k), 32'(valid_a), (k < 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("tput%0d dout_a", k), dout_a, 32'h10 + 32'((k < 3) ? k : 3));
      checkOutput($sformatf("tput%0d valid_b", k), 32'(valid_b), (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("tput%0d dout_b", k), dout_b,
                  (k == 0) ? 32'hCAFE0001 : 32'h10 + 32'((k - 1 < 3) ? k - 1 : 3));
    end
    enB = 1'b0;

    // Read-during-write on the same address, then on different addresses.
    do_write(9'd7, 32'h12345678, 4'hF);
    enA = 1'b1; addrA = 9'd7; dinA = 32'hFFFFFFFF; weA = 4'b0011;
    do_read("rdw", 9'd7, 32'h12345678, 32'h1234FFFF);
    do_read("rdw after", 9'd7, 32'h1234FFFF, 32'h1234FFFF);
    enA = 1'b1; addrA = 9'd8; dinA = 32'h77; weA = 4'hF;
    do_read("rdw diff", 9'd1, 32'h10, 32'h10);

    // Runtime clear with a same-cycle write and read, then blocked traffic while busy.
    clr = 1'b1; enA = 1'b1; addrA = 9'd9; dinA = 32'h99; weA = 4'hF;
    enB = 1'b1; addrB = 9'd1;
    step();
    clr = 1'b0; enA = 1'b1; addrA = 9'd3; dinA = 32'h55; enB = 1'b1; addrB = 9'd3;
    checkOutput("clr busy_a", 32'(busy_a), 32'd1);
    checkOutput("clr busy_b", 32'(busy_b), 32'd1);
    checkOutput("clr rd valid_a", 32'(valid_a), 32'd1);
    checkOutput("clr rd dout_a", dout_a, 32'h10);
    ca = 1; cb = 1;
    step();
    checkOutput("clr rd valid_b", 32'(valid_b), 32'd1);
    checkOutput("clr rd dout_b", dout_b, 32'h10);
    checkOutput("clr blocked valid_a", 32'(valid_a), 32'd0);
    stray = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (i > 0 && (valid_a || valid_b)) stray++;
      if (!busy_a && !busy_b) break;
      enA = (i < 250);
      enB = (i < 250);
      clr = (i == 150);
      step();
    end
    enA = 1'b0; enB = 1'b0; clr = 1'b0;
    checkOutput("clr len a", ca, 32'd512);
    checkOutput("clr len b", cb, 32'd300);
    checkOutput("reads while busy", stray, 32'd0);
    do_read("after clr a3", 9'd3, 32'h0, 32'h0);
    do_read("after clr a9", 9'd9, 32'h0, 32'h0);

    // Reset in the middle of a clear restarts it.
    do_write(9'd3, 32'h5A5A5A5A, 4'hF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (99) step();
    checkOutput("mid busy_a", 32'(busy_a), 32'd1);
    rst = 1'b1;
    step();
    step();
    checkOutput("mid rst busy_a", 32'(busy_a), 32'd1);
    checkOutput("mid rst busy_b", 32'(busy_b), 32'd1);
    rst = 1'b0;
    count_clear(ca, cb);
    checkOutput("restart len a", ca, 32'd512);
    checkOutput("restart len b", cb, 32'd300);
    do_read("after restart a3", 9'd3, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
